// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline controller.
//   - update command codes driven onto fd/de/ew pipeline registers
//   - controller state encoding
//   - register-id, index, write-enable and counter widths
package pipe_pkg;

    localparam int UPD_W     = 2;
    localparam int REG_ID_W  = 6;   // bit5 = FP file, [4:0] = index
    localparam int REG_IDX_W = 5;
    localparam int RW_W      = 2;   // nonzero = writes, bit1 = FP file
    localparam int CNT_W     = 5;

    localparam logic [UPD_W-1:0] UPD_HOLD  = 2'b00;
    localparam logic [UPD_W-1:0] UPD_ADV   = 2'b01;
    localparam logic [UPD_W-1:0] UPD_FLUSH = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/reg_match.sv
// reg_match: flags a read-after-write hazard between one decode-stage
// source register and the E-stage destination.
// Ports:
//   r_i   [5:0] decode source register (bit5 = FP file)
//   rw_i  [1:0] E-stage write enable (nonzero = writes, bit1 = FP file)
//   rd_i  [4:0] E-stage destination index
//   hit_o       source matches the pending E-stage write
module reg_match
    import pipe_pkg::*;
(
    input  logic [REG_ID_W-1:0]  r_i,
    input  logic [RW_W-1:0]      rw_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    output logic                 hit_o
);

    // Register 0 is deliberately not treated as a hardwired zero here.
    assign hit_o = (rw_i != '0)
                && (rw_i[1] == r_i[REG_ID_W-1])
                && (rd_i == r_i[REG_IDX_W-1:0]);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt controller for a fetch-decode-execute
// pipeline.
// Ports:
//   clk, rstn                     clock, async active-low reset
//   d_rs, d_rt       [5:0]        decode-stage source registers
//   de_rw            [1:0]        E-stage write enable
//   de_rd            [4:0]        E-stage destination index
//   de_is_load                    E-stage result not forwardable yet
//   de_wait_time     [4:0]        extra E cycles needed (0 = single cycle)
//   e_redirect                    E-stage branch/jump taken
//   de_stop                       E-stage instruction is a stop
//   resume                        pulse to leave HALT
//   fd_update, de_update,
//   ew_update        [1:0]        pipeline register commands (hold/adv/flush)
//   pc_en                         PC loads next PC
//   e_busy                        multi-cycle stall in progress
//   halted                        core stopped
//   dbg_state        [1:0]        current controller state
module pipeline_ctrl
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [REG_ID_W-1:0]  d_rs,
    input  logic [REG_ID_W-1:0]  d_rt,
    input  logic [RW_W-1:0]      de_rw,
    input  logic [REG_IDX_W-1:0] de_rd,
    input  logic                 de_is_load,
    input  logic [CNT_W-1:0]     de_wait_time,
    input  logic                 e_redirect,
    input  logic                 de_stop,
    input  logic                 resume,
    output logic [UPD_W-1:0]     fd_update,
    output logic [UPD_W-1:0]     de_update,
    output logic [UPD_W-1:0]     ew_update,
    output logic                 pc_en,
    output logic                 e_busy,
    output logic                 halted,
    output logic [1:0]           dbg_state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rs_hit, rt_hit, load_use;
    logic stall, complete;

    reg_match u_match_rs (
        .r_i   (d_rs),
        .rw_i  (de_rw),
        .rd_i  (de_rd),
        .hit_o (rs_hit)
    );

    reg_match u_match_rt (
        .r_i   (d_rt),
        .rw_i  (de_rw),
        .rd_i  (de_rd),
        .hit_o (rt_hit)
    );

    assign load_use  = de_is_load && (rs_hit || rt_hit);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fd_update = UPD_HOLD;
        de_update = UPD_HOLD;
        ew_update = UPD_HOLD;
        pc_en     = 1'b0;
        e_busy    = 1'b0;
        halted    = 1'b0;
        stall     = 1'b0;
        complete  = 1'b0;

        if (!rstn) begin
            // Outputs stay quiet for as long as reset is held.
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (de_wait_time != '0) begin
                        // This cycle is the first of N stall cycles, so
                        // N-1 further cycles remain before release.
                        stall   = 1'b1;
                        cnt_d   = de_wait_time - 5'd1;
                        state_d = ST_WAIT;
                    end else begin
                        complete = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        stall = 1'b1;
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        // Release: the held wait_time is ignored now.
                        complete = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (resume) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase

            if (stall) begin
                // Keep the instruction in E; send a bubble downstream.
                ew_update = UPD_FLUSH;
                e_busy    = 1'b1;
            end

            if (complete) begin
                if (de_stop) begin
                    fd_update = UPD_FLUSH;
                    de_update = UPD_FLUSH;
                    ew_update = UPD_ADV;
                    state_d   = ST_HALT;
                end else if (e_redirect) begin
                    fd_update = UPD_FLUSH;
                    de_update = UPD_FLUSH;
                    ew_update = UPD_ADV;
                    pc_en     = 1'b1;
                end else if (load_use) begin
                    de_update = UPD_FLUSH;
                    ew_update = UPD_ADV;
                end else begin
                    fd_update = UPD_ADV;
                    de_update = UPD_ADV;
                    ew_update = UPD_ADV;
                    pc_en     = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] d_rs, d_rt;
  logic [1:0] de_rw;
  logic [4:0] de_rd;
  logic       de_is_load;
  logic [4:0] de_wait_time;
  logic       e_redirect, de_stop, resume;
  logic [1:0] fd_update, de_update, ew_update;
  logic       pc_en, e_busy, halted;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  // {fd, de, ew, pc_en, e_busy, halted}
  logic [8:0] obs;
  assign obs = {fd_update, de_update, ew_update, pc_en, e_busy, halted};

  localparam logic [8:0] EXP_RST   = 9'b00_00_00_0_0_0;
  localparam logic [8:0] EXP_ADV   = 9'b01_01_01_1_0_0;
  localparam logic [8:0] EXP_STALL = 9'b00_00_10_0_1_0;
  localparam logic [8:0] EXP_LU    = 9'b00_10_01_0_0_0;
  localparam logic [8:0] EXP_REDIR = 9'b10_10_01_1_0_0;
  localparam logic [8:0] EXP_STOP  = 9'b10_10_01_0_0_0;
  localparam logic [8:0] EXP_HALT  = 9'b00_00_00_0_0_1;

  pipeline_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .de_rw        (de_rw),
    .de_rd        (de_rd),
    .de_is_load   (de_is_load),
    .de_wait_time (de_wait_time),
    .e_redirect   (e_redirect),
    .de_stop      (de_stop),
    .resume       (resume),
    .fd_update    (fd_update),
    .de_update    (de_update),
    .ew_update    (ew_update),
    .pc_en        (pc_en),
    .e_busy       (e_busy),
    .halted       (halted),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout got running required finished");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_nop();
    d_rs = '0; d_rt = '0; de_rw = '0; de_rd = '0;
    de_is_load = 1'b0; de_wait_time = '0;
    e_redirect = 1'b0; de_stop = 1'b0; resume = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_nop();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== EXP_RST) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d got %b required %b", i, obs, EXP_RST);
      end
      checks++;
      if (dbg_state !== ST_RUN) begin
        failures++;
        $display("FAIL reset_state got %0d required %0d", dbg_state, ST_RUN);
      end
    end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== EXP_ADV) begin
        failures++;
        $display("FAIL post_reset_nop cyc%0d got %b required %b", i, obs, EXP_ADV);
      end
      tick();
    end
  endtask

  task automatic test_multicycle();
    de_wait_time = 5'd3; de_rw = 2'b01; de_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== EXP_STALL) begin
        failures++;
        $display("FAIL wait3_stall cyc%0d got %b required %b", i, obs, EXP_STALL);
      end
      if (i > 0) begin
        checks++;
        if (dbg_state !== ST_WAIT) begin
          failures++;
          $display("FAIL wait3_state cyc%0d got %0d required %0d", i, dbg_state, ST_WAIT);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (obs !== EXP_ADV) begin
      failures++;
      $display("FAIL wait3_release got %b required %b", obs, EXP_ADV);
    end
    tick();
    set_nop();
  endtask

  task automatic test_load_use();
    logic [5:0] v_rs  [8] = '{6'o00, 6'o00, 6'o05, 6'o05, 6'o45, 6'o45, 6'o00, 6'o05};
    logic [5:0] v_rt  [8] = '{6'o05, 6'o45, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00};
    logic [1:0] v_rw  [8] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b01};
    logic [4:0] v_rd  [8] = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd0, 5'd5};
    logic       v_ld  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [8:0] v_exp [8] = '{EXP_LU, EXP_ADV, EXP_LU, EXP_ADV,
                              EXP_LU, EXP_LU, EXP_LU, EXP_ADV};
    for (int i = 0; i < 8; i++) begin
      set_nop();
      d_rs = v_rs[i]; d_rt = v_rt[i]; de_rw = v_rw[i];
      de_rd = v_rd[i]; de_is_load = v_ld[i];
      @(negedge clk);
      checks++;
      if (obs !== v_exp[i]) begin
        failures++;
        $display("FAIL load_use vec%0d got %b required %b", i, obs, v_exp[i]);
      end
      tick();
    end
    set_nop();
  endtask

  task automatic test_redirect();
    de_wait_time = 5'd2; e_redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== EXP_STALL) begin
        failures++;
        $display("FAIL redirect_in_wait cyc%0d got %b required %b", i, obs, EXP_STALL);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (obs !== EXP_REDIR) begin
      failures++;
      $display("FAIL redirect_release got %b required %b", obs, EXP_REDIR);
    end
    tick();
    // redirect outranks a simultaneous load-use
    set_nop();
    e_redirect = 1'b1; de_is_load = 1'b1; de_rw = 2'b01; de_rd = 5'd3; d_rs = 6'd3;
    @(negedge clk);
    checks++;
    if (obs !== EXP_REDIR) begin
      failures++;
      $display("FAIL redirect_over_load got %b required %b", obs, EXP_REDIR);
    end
    tick();
    set_nop();
  endtask

  task automatic test_stop();
    de_stop = 1'b1; e_redirect = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== EXP_STOP) begin
      failures++;
      $display("FAIL stop got %b required %b", obs, EXP_STOP);
    end
    tick();
    set_nop();
    e_redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== EXP_HALT) begin
        failures++;
        $display("FAIL halt_hold cyc%0d got %b required %b", i, obs, EXP_HALT);
      end
      checks++;
      if (dbg_state !== ST_HALT) begin
        failures++;
        $display("FAIL halt_state got %0d required %0d", dbg_state, ST_HALT);
      end
      tick();
    end
    e_redirect = 1'b0; resume = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== EXP_HALT) begin
      failures++;
      $display("FAIL resume_cycle got %b required %b", obs, EXP_HALT);
    end
    tick();
    resume = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== EXP_ADV) begin
      failures++;
      $display("FAIL after_resume got %b required %b", obs, EXP_ADV);
    end
    tick();
    // resume while running has no effect
    resume = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== EXP_ADV) begin
      failures++;
      $display("FAIL resume_in_run got %b required %b", obs, EXP_ADV);
    end
    tick();
    resume = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_RUN) begin
      failures++;
      $display("FAIL resume_in_run_state got %0d required %0d", dbg_state, ST_RUN);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    set_nop();
    de_wait_time = 5'd5;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (obs !== EXP_STALL || dbg_state !== ST_WAIT) begin
      failures++;
      $display("FAIL abort_pre got %b/%0d required %b/%0d", obs, dbg_state, EXP_STALL, ST_WAIT);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (obs !== EXP_RST) begin
      failures++;
      $display("FAIL abort_wait_outputs got %b required %b", obs, EXP_RST);
    end
    checks++;
    if (dbg_state !== ST_RUN) begin
      failures++;
      $display("FAIL abort_wait_state got %0d required %0d", dbg_state, ST_RUN);
    end
    tick();
    rstn = 1'b1; de_wait_time = '0;
    @(negedge clk);
    checks++;
    if (obs !== EXP_ADV) begin
      failures++;
      $display("FAIL abort_wait_after got %b required %b", obs, EXP_ADV);
    end
    tick();
    // stall outranks stop; stop then lands on release
    de_stop = 1'b1; de_wait_time = 5'd1;
    @(negedge clk);
    checks++;
    if (obs !== EXP_STALL) begin
      failures++;
      $display("FAIL stall_over_stop got %b required %b", obs, EXP_STALL);
    end
    tick();
    @(negedge clk);
    checks++;
    if (obs !== EXP_STOP) begin
      failures++;
      $display("FAIL stop_on_release got %b required %b", obs, EXP_STOP);
    end
    tick();
    set_nop();
    @(negedge clk);
    checks++;
    if (obs !== EXP_HALT) begin
      failures++;
      $display("FAIL halt_before_abort got %b required %b", obs, EXP_HALT);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (obs !== EXP_RST || dbg_state !== ST_RUN) begin
      failures++;
      $display("FAIL abort_halt got %b/%0d required %b/%0d", obs, dbg_state, EXP_RST, ST_RUN);
    end
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== EXP_ADV) begin
      failures++;
      $display("FAIL abort_halt_after got %b required %b", obs, EXP_ADV);
    end
    tick();
  endtask

  task automatic test_wait31();
    int n;
    set_nop();
    de_wait_time = 5'd31;
    n = 0;
    @(negedge clk);
    while (obs === EXP_STALL && n < 40) begin
      n++;
      tick();
      @(negedge clk);
    end
    checks++;
    if (n != 31) begin
      failures++;
      $display("FAIL wait31_count got %0d required %0d", n, 31);
    end
    checks++;
    if (obs !== EXP_ADV) begin
      failures++;
      $display("FAIL wait31_release got %b required %b", obs, EXP_ADV);
    end
    tick();
    set_nop();
  endtask

  initial begin
    test_reset();
    test_multicycle();
    test_load_use();
    test_redirect();
    test_stop();
    test_reset_abort();
    test_wait31();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
